// File: rtl/spike_pkg.sv
// Shared types and helpers for the spike encode/decode blocks.
`default_nettype none

package spike_pkg;

  typedef enum logic [0:0] {
    DEC_IDLE  = 1'b0,
    DEC_COUNT = 1'b1
  } dec_state_e;

  localparam int DEF_WINDOW_LEN = 16;
  localparam int WIN_W          = $clog2(DEF_WINDOW_LEN);

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spike_out_reg.sv
// spike_out_reg: valid/ready output register with sticky overrun flag.
`default_nettype none

module spike_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              ovr_q;
  logic              ovr_set;

  // A load into a register that the consumer is taking this edge is not an overrun.
  assign ovr_set = load_i && valid_q && !ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (load_i) begin
        data_q  <= data_i;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end

      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (clr_i) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

`default_nettype wire

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes per WINDOW_LEN-cycle window and presents the rate.
// Optional smoothing of the reported rate is enabled with SPIKE_DEC_EMA_EN.
`default_nettype none

module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int WINDOW_LEN = 16,
  parameter int CNT_W      = 8,
  parameter int EMA_SHIFT  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             spike_i,
  output logic [CNT_W-1:0] rate_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o,
  input  logic             clr_ovr_i,
  output logic             win_last_o
);

  localparam int WCNT_W = (WINDOW_LEN == DEF_WINDOW_LEN) ? WIN_W : $clog2(WINDOW_LEN);
  localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WINDOW_LEN - 1);
  localparam logic [31:0]       CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);

  if (WINDOW_LEN < 2 || WINDOW_LEN > 65535 || EMA_SHIFT < 1 || EMA_SHIFT >= CNT_W) begin : g_param_check
    $error("spike_rate_decoder: parameter out of legal range");
  end

  dec_state_e        state_q;
  logic [WCNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]  spike_cnt_q, spike_cnt_d;
  logic [CNT_W-1:0]  cnt_final;
  logic [CNT_W-1:0]  load_data;
  logic              win_end;
  logic              load;

  assign win_end    = (state_q == DEC_COUNT) && (win_cnt_q == WIN_LAST);
  assign win_last_o = win_end;
  // Count including the current cycle's spike, so the last-cycle spike joins its window.
  assign cnt_final  = spike_i ? CNT_W'(sat_inc(32'(spike_cnt_q), CNT_MAX)) : spike_cnt_q;
  assign load       = en_i && win_end;

  always_comb begin
    win_cnt_d   = win_cnt_q + WCNT_W'(1);
    spike_cnt_d = cnt_final;
    if (!en_i || win_end) begin
      win_cnt_d   = '0;
      spike_cnt_d = '0;
    end
  end

  // In IDLE both counters sit at 0, so the enabling cycle behaves as window cycle 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= DEC_IDLE;
      win_cnt_q   <= '0;
      spike_cnt_q <= '0;
    end else begin
      case (state_q)
        DEC_IDLE:  state_q <= en_i ? DEC_COUNT : DEC_IDLE;
        DEC_COUNT: state_q <= en_i ? DEC_COUNT : DEC_IDLE;
        default:   state_q <= DEC_IDLE;
      endcase
      win_cnt_q   <= win_cnt_d;
      spike_cnt_q <= spike_cnt_d;
    end
  end

`ifdef SPIKE_DEC_EMA_EN
  localparam int EW = CNT_W + 2;
  localparam logic signed [EW-1:0] EMA_MAX = EW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]       ema_q;
  logic [CNT_W-1:0]       ema_next;
  logic signed [EW-1:0]   ema_diff;
  logic signed [EW-1:0]   ema_sum;

  always_comb begin
    ema_diff = $signed({2'b00, cnt_final}) - $signed({2'b00, ema_q});
    ema_sum  = $signed({2'b00, ema_q}) + (ema_diff >>> EMA_SHIFT);
    if (ema_sum < 0) begin
      ema_next = '0;
    end else if (ema_sum > EMA_MAX) begin
      ema_next = EMA_MAX[CNT_W-1:0];
    end else begin
      ema_next = ema_sum[CNT_W-1:0];
    end
  end

  // Smoothing history survives early disable; only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ema_q <= '0;
    end else if (load) begin
      ema_q <= ema_next;
    end
  end

  assign load_data = ema_next;
`else
  assign load_data = cnt_final;
`endif

  spike_out_reg #(
    .DATA_W (CNT_W)
  ) u_out_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .data_i    (load_data),
    .ready_i   (ready_i),
    .clr_i     (clr_ovr_i),
    .data_o    (rate_o),
    .valid_o   (valid_o),
    .overrun_o (overrun_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder (default width and a CNT_W=4 copy).
`default_nettype none

module tb_spike_rate_decoder;

  localparam int WL   = 16;
  localparam int CW   = 8;
  localparam int CW2  = 4;
  localparam int SH   = 2;
  localparam int MAX1 = 255;
  localparam int MAX2 = 15;

  logic           clk = 1'b0;
  logic           rst, en, spike, ready, clr;
  logic [CW-1:0]  rate;
  logic           valid, ovr, win_last;
  logic [CW2-1:0] rate2;
  logic           valid2, ovr2, win_last2;

  int errors = 0;
  int checks = 0;

  // Reference state: window position, uncapped spike sum, output register.
  bit m_active;
  int m_pos;
  int m_sum;
  int m_rate;
  bit m_valid;
  bit m_ovr;
`ifdef SPIKE_DEC_EMA_EN
  int m_ema;
`endif

  typedef struct {
    logic [15:0] mask;
    int          raw;
    int          ema;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW_LEN(WL), .CNT_W(CW), .EMA_SHIFT(SH)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .spike_i(spike), .rate_o(rate),
    .valid_o(valid), .ready_i(ready), .overrun_o(ovr), .clr_ovr_i(clr),
    .win_last_o(win_last)
  );

  spike_rate_decoder #(.WINDOW_LEN(WL), .CNT_W(CW2), .EMA_SHIFT(SH)) dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .spike_i(spike), .rate_o(rate2),
    .valid_o(valid2), .ready_i(ready), .overrun_o(ovr2), .clr_ovr_i(clr),
    .win_last_o(win_last2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_sum = 0;
    m_rate = 0; m_valid = 0; m_ovr = 0;
`ifdef SPIKE_DEC_EMA_EN
    m_ema = 0;
`endif
  endtask

  task automatic model_edge(input bit e, input bit s, input bit r, input bit c);
    bit win_end;
    bit load;
    bit set_ovr;
    int res;
    win_end = m_active && (m_pos == WL - 1);
    load    = e && win_end;
    res     = 0;
    if (!e) begin
      m_active = 0; m_pos = 0; m_sum = 0;
    end else begin
      m_sum = m_sum + int'(s);
      res   = (m_sum > MAX1) ? MAX1 : m_sum;
      if (win_end) begin
        m_pos = 0; m_sum = 0;
      end else begin
        m_pos = m_pos + 1;
      end
      m_active = 1;
    end
    set_ovr = load && m_valid && !r;
    if (load) begin
`ifdef SPIKE_DEC_EMA_EN
      m_ema = m_ema + ((res - m_ema) >>> SH);
      if (m_ema < 0) m_ema = 0;
      if (m_ema > MAX1) m_ema = MAX1;
      m_rate = m_ema;
`else
      m_rate = res;
`endif
      m_valid = 1;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    if (set_ovr) m_ovr = 1;
    else if (c) m_ovr = 0;
  endtask

  // One clock cycle: drive, check the combinational flag, clock, check registered outputs.
  task automatic cycle(input bit e, input bit s, input bit r, input bit c);
    int exp_last;
    en = e; spike = s; ready = r; clr = c;
    #1;
    exp_last = (m_active && m_pos == WL - 1) ? 1 : 0;
    chk("win_last", int'(win_last), exp_last);
    chk("win_last_cw4", int'(win_last2), exp_last);
    @(posedge clk);
    model_edge(e, s, r, c);
    @(negedge clk);
    chk("rate", int'(rate), m_rate);
    chk("valid", int'(valid), int'(m_valid));
    chk("overrun", int'(ovr), int'(m_ovr));
    chk("valid_cw4", int'(valid2), int'(m_valid));
    chk("overrun_cw4", int'(ovr2), int'(m_ovr));
  endtask

  task automatic run_window(input logic [15:0] mask, input bit r);
    for (int c = 0; c < WL; c++) cycle(1'b1, mask[c], r, 1'b0);
  endtask

  initial begin
    int exp1, exp2;
    tbl[0] = '{16'h00FF, 8,  2};
    tbl[1] = '{16'hAAAA, 8,  3};
    tbl[2] = '{16'h0000, 0,  2};
    tbl[3] = '{16'h001F, 5,  2};
    tbl[4] = '{16'h8000, 1,  1};
    tbl[5] = '{16'hFFFF, 16, 4};

    rst = 1'b1; en = 1'b0; spike = 1'b0; ready = 1'b0; clr = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_rate", int'(rate), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_overrun", int'(ovr), 0);
    chk("rst_win_last", int'(win_last), 0);
    rst = 1'b0;

    // Back-to-back windows from reset; each load is consumed immediately.
    for (int i = 0; i < 6; i++) begin
      run_window(tbl[i].mask, 1'b1);
`ifdef SPIKE_DEC_EMA_EN
      exp1 = tbl[i].ema;
      exp2 = tbl[i].ema;
`else
      exp1 = tbl[i].raw;
      exp2 = (tbl[i].raw > MAX2) ? MAX2 : tbl[i].raw;
`endif
      chk("tbl_valid", int'(valid), 1);
      chk("tbl_rate", int'(rate), exp1);
      chk("tbl_rate_cw4", int'(rate2), exp2);
    end

    // Overrun: two unconsumed windows, then clear and drain.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    run_window(16'h0007, 1'b0);
    run_window(16'h007F, 1'b0);
`ifndef SPIKE_DEC_EMA_EN
    chk("ovr_rate", int'(rate), 7);
`endif
    chk("ovr_valid", int'(valid), 1);
    chk("ovr_flag", int'(ovr), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_cleared", int'(ovr), 0);
    chk("ovr_valid_held", int'(valid), 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_drained", int'(valid), 0);

    // Early disable at window cycle 9 with 4 spikes counted.
    for (int c = 0; c < 9; c++) cycle(1'b1, (c < 4), 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("early_no_valid", int'(valid), 0);
    run_window(16'h3F00, 1'b1);
`ifndef SPIKE_DEC_EMA_EN
    chk("reenable_rate", int'(rate), 6);
`endif
    chk("reenable_valid", int'(valid), 1);

    // Window end on the cycle en_i drops: discarded.
    for (int c = 0; c < WL - 1; c++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("end_disabled_no_valid", int'(valid), 0);

    // Asynchronous reset in the middle of a window with pending data and overrun.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    run_window(16'h0F0F, 1'b0);
    run_window(16'h00F0, 1'b0);
    for (int c = 0; c < 5; c++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_rate", int'(rate), 0);
    chk("arst_rate_cw4", int'(rate2), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_overrun", int'(ovr), 0);
    chk("arst_win_last", int'(win_last), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic with alternating consumer pressure.
    for (int i = 0; i < 1500; i++) begin
      bit e, s, r, c;
      e = ($urandom_range(0, 31) != 0);
      s = $urandom_range(0, 1) == 1;
      r = ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      cycle(e, s, r, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
